// File: rtl/rv32v_pipe_sequencer.sv
// Stall/flush sequencer for the five-stage RV32V vector pipe.
// Turns stage busy signals into backpressure and runs the flush/redirect/drain sequence on memory-stage events.
module rv32v_pipe_sequencer #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             busy_f1,
  input  logic             busy_f2,
  input  logic             busy_dec,
  input  logic             busy_ex,
  input  logic             busy_mem,
  input  logic             csr_update,
  input  logic             exception_mem,
  output logic             stall_f1,
  output logic             stall_f2,
  output logic             stall_dec,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_f1,
  output logic             flush_f2,
  output logic             flush_dec,
  output logic             flush_ex,
  output logic             flush_mem,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic             redirect_cause,
  output logic [1:0]       seq_state,
  output logic [CNT_W-1:0] event_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } seq_state_t;

  seq_state_t state, next_state;
  logic [3:0] drain_cnt;
  logic [4:0] busy_v, bp_src, bp_stall, bp_flush;
  logic [4:0] stall_v, flush_v;
  logic       accept;

  assign busy_v = {busy_mem, busy_ex, busy_dec, busy_f2, busy_f1};
  assign accept = (state == ST_RUN) && !RST && (csr_update || exception_mem) && !busy_mem;

  // Stage i stalls if it or any older stage is busy; the first non-stalled stage after a stalled one gets the bubble.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    bp_stall = '0;
    bp_flush = '0;
    bp_src   = (state == ST_DRAIN) ? {3'b000, busy_v[1:0]} : busy_v;
    for (int i = 0; i < 5; i++) bp_stall[i] = |(bp_src >> i);
    for (int i = 1; i < 5; i++) bp_flush[i] = bp_stall[i-1] & ~bp_stall[i];
  end

  always_comb begin
    stall_v        = '0;
    flush_v        = '0;
    redirect_valid = 1'b0;
    next_state     = state;
    if (RST) begin
      flush_v = 5'b11111;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            flush_v    = 5'b01111;
            next_state = ST_REDIRECT;
          end else begin
            stall_v = bp_stall;
            flush_v = bp_flush;
          end
        end
        ST_REDIRECT: begin
          redirect_valid = 1'b1;
          stall_v        = 5'b00001;
          flush_v        = 5'b11110;
          if (redirect_ready) next_state = (DRAIN_CYCLES == 0) ? ST_RUN : ST_DRAIN;
        end
        ST_DRAIN: begin
          stall_v = bp_stall;
          flush_v = bp_flush | 5'b01100;
          if (drain_cnt == 4'd1) next_state = ST_RUN;
        end
        default: next_state = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= ST_RUN;
      redirect_cause <= 1'b0;
      event_count    <= '0;
      drain_cnt      <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        redirect_cause <= exception_mem;
        if (event_count != {CNT_W{1'b1}}) event_count <= event_count + 1'b1;
      end
      if (state == ST_REDIRECT && redirect_ready) drain_cnt <= 4'(DRAIN_CYCLES);
      else if (state == ST_DRAIN)                  drain_cnt <= drain_cnt - 4'd1;
    end
  end

  assign seq_state = state;
  assign {stall_mem, stall_ex, stall_dec, stall_f2, stall_f1} = stall_v;
  assign {flush_mem, flush_ex, flush_dec, flush_f2, flush_f1} = flush_v;

endmodule

// File: tb/tb_rv32v_pipe_sequencer.sv
// Self-checking bench for rv32v_pipe_sequencer: directed scenarios plus randomized traffic against a cycle model.
// A second instance with CNT_W=2 shares all inputs to exercise counter saturation.
module tb_rv32v_pipe_sequencer;

  localparam int DRAIN = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] busy = '0;
  logic       csr = 1'b0, exc = 1'b0, rdy = 1'b0;

  logic [4:0] stall, flush;
  logic       rv, cause;
  logic [1:0] st;
  logic [7:0] cnt;

  logic [4:0] s2, f2;
  logic       rv2, cause2;
  logic [1:0] st2;
  logic [1:0] cnt2;

  int n_pass = 0, n_total = 0;

  // model state: mode 0 RUN, 1 REDIRECT, 2 DRAIN
  int m_mode = 0, m_left = 0, m_count = 0, m_count2 = 0;
  bit m_cause = 1'b0;

  always #5 CLK = ~CLK;

  rv32v_pipe_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .busy_f1(busy[0]), .busy_f2(busy[1]), .busy_dec(busy[2]), .busy_ex(busy[3]), .busy_mem(busy[4]),
    .csr_update(csr), .exception_mem(exc),
    .stall_f1(stall[0]), .stall_f2(stall[1]), .stall_dec(stall[2]), .stall_ex(stall[3]), .stall_mem(stall[4]),
    .flush_f1(flush[0]), .flush_f2(flush[1]), .flush_dec(flush[2]), .flush_ex(flush[3]), .flush_mem(flush[4]),
    .redirect_valid(rv), .redirect_ready(rdy), .redirect_cause(cause),
    .seq_state(st), .event_count(cnt)
  );

  rv32v_pipe_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST),
    .busy_f1(busy[0]), .busy_f2(busy[1]), .busy_dec(busy[2]), .busy_ex(busy[3]), .busy_mem(busy[4]),
    .csr_update(csr), .exception_mem(exc),
    .stall_f1(s2[0]), .stall_f2(s2[1]), .stall_dec(s2[2]), .stall_ex(s2[3]), .stall_mem(s2[4]),
    .flush_f1(f2[0]), .flush_f2(f2[1]), .flush_dec(f2[2]), .flush_ex(f2[3]), .flush_mem(f2[4]),
    .redirect_valid(rv2), .redirect_ready(rdy), .redirect_cause(cause2),
    .seq_state(st2), .event_count(cnt2)
  );

  // Reference model: a sequence of modes with a remaining-cycle count for the drain window.
  always @(posedge CLK) begin
    if (RST) begin
      m_mode <= 0; m_left <= 0; m_cause <= 1'b0; m_count <= 0; m_count2 <= 0;
    end else if (m_mode == 0) begin
      if ((csr || exc) && !busy[4]) begin
        m_mode   <= 1;
        m_cause  <= exc;
        m_count  <= (m_count  < 255) ? m_count  + 1 : 255;
        m_count2 <= (m_count2 < 3)   ? m_count2 + 1 : 3;
      end
    end else if (m_mode == 1) begin
      if (rdy) begin
        m_mode <= (DRAIN == 0) ? 0 : 2;
        m_left <= DRAIN;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) m_mode <= 0;
    end
  end

  // Expected {stall, flush, redirect_valid} from current inputs and model mode.
  function automatic logic [10:0] exp_comb();
    logic [4:0] s, f;
    int k, top;
    s = '0; f = '0;
    if (RST) return {5'b00000, 5'b11111, 1'b0};
    if (m_mode == 1) return {5'b00001, 5'b11110, 1'b1};
    if (m_mode == 0 && (csr || exc) && !busy[4]) return {5'b00000, 5'b01111, 1'b0};
    top = (m_mode == 2) ? 1 : 4;
    k = -1;
    for (int i = 0; i <= top; i++) if (busy[i]) k = i;
    for (int i = 0; i <= k; i++) s[i] = 1'b1;
    if (k >= 0 && k < 4) f[k+1] = 1'b1;
    if (m_mode == 2) f = f | 5'b01100;
    return {s, f, 1'b0};
  endfunction

  task automatic drive(input logic [4:0] b, input logic c, input logic e, input logic r, input logic rs);
    @(negedge CLK);
    busy = b; csr = c; exc = e; rdy = r; RST = rs;
    #1;
  endtask

  task automatic do_reset();
    drive(5'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(5'b10101, 1'b1, 1'b1, 1'b1, 1'b1);
    n_total++;
    if ({stall, flush, rv} !== {5'b00000, 5'b11111, 1'b0})
      $display("FAIL reset_comb: got stall=%b flush=%b rv=%b want 00000/11111/0", stall, flush, rv);
    else n_pass++;
    drive(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if ({st, cause, cnt, cnt2} !== {2'd0, 1'b0, 8'd0, 2'd0})
      $display("FAIL reset_regs: got st=%0d cause=%b cnt=%0d cnt2=%0d want 0/0/0/0", st, cause, cnt, cnt2);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    drive(5'b01000, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if ({stall, flush} !== {5'b01111, 5'b10000})
      $display("FAIL bp_ex: got stall=%b flush=%b want 01111/10000", stall, flush);
    else n_pass++;
    drive(5'b00010, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if ({stall, flush} !== {5'b00011, 5'b00100})
      $display("FAIL bp_f2: got stall=%b flush=%b want 00011/00100", stall, flush);
    else n_pass++;
    drive(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if ({stall, flush} !== 10'b0)
      $display("FAIL bp_idle: got stall=%b flush=%b want 00000/00000", stall, flush);
    else n_pass++;
  endtask

  task automatic test_csr_event();
    logic [1:0] want_st [5] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
    do_reset();
    drive(5'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({stall, flush, rv, st} !== {5'b00000, 5'b01111, 1'b0, 2'd0})
      $display("FAIL csr_accept: got stall=%b flush=%b rv=%b st=%0d want 00000/01111/0/0", stall, flush, rv, st);
    else n_pass++;
    for (int t = 1; t < 5; t++) begin
      drive(5'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_total++;
      if (st !== want_st[t] || rv !== (t == 1))
        $display("FAIL csr_seq_T%0d: got st=%0d rv=%b want st=%0d rv=%b", t, st, rv, want_st[t], (t == 1));
      else n_pass++;
    end
    n_total++;
    if ({cause, cnt} !== {1'b0, 8'd1})
      $display("FAIL csr_regs: got cause=%b cnt=%0d want 0/1", cause, cnt);
    else n_pass++;
  endtask

  task automatic test_deferred();
    do_reset();
    for (int t = 0; t < 3; t++) begin
      drive(5'b10000, 1'b0, 1'b1, 1'b1, 1'b0);
      n_total++;
      if ({stall, flush, st} !== {5'b11111, 5'b00000, 2'd0})
        $display("FAIL deferred_hold%0d: got stall=%b flush=%b st=%0d want 11111/00000/0", t, stall, flush, st);
      else n_pass++;
    end
    drive(5'b00000, 1'b0, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (flush !== 5'b01111)
      $display("FAIL deferred_accept: got flush=%b want 01111", flush);
    else n_pass++;
    drive(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if ({st, cause, cnt} !== {2'd1, 1'b1, 8'd1})
      $display("FAIL deferred_regs: got st=%0d cause=%b cnt=%0d want 1/1/1", st, cause, cnt);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(5'b00000, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
    n_total++;
    if ({st, cause, cnt} !== {2'd1, 1'b1, 8'd1})
      $display("FAIL simultaneous: got st=%0d cause=%b cnt=%0d want 1/1/1", st, cause, cnt);
    else n_pass++;
  endtask

  task automatic test_held_ready();
    do_reset();
    drive(5'b00000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 5; t++) begin
      drive(5'b11111, t[0], ~t[0], 1'b0, 1'b0);
      n_total++;
      if ({rv, stall, flush, st, cnt} !== {1'b1, 5'b00001, 5'b11110, 2'd1, 8'd1})
        $display("FAIL held_ready%0d: got rv=%b stall=%b flush=%b st=%0d cnt=%0d want 1/00001/11110/1/1",
                 t, rv, stall, flush, st, cnt);
      else n_pass++;
    end
    drive(5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(5'b00010, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if ({st, rv, stall, flush, cause} !== {2'd2, 1'b0, 5'b00011, 5'b01100, 1'b0})
      $display("FAIL held_drain: got st=%0d rv=%b stall=%b flush=%b cause=%b want 2/0/00011/01100/0",
               st, rv, stall, flush, cause);
    else n_pass++;
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    drive(5'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(5'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(5'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_total++;
    if ({st, stall, flush, rv} !== {2'd2, 5'b00000, 5'b11111, 1'b0})
      $display("FAIL rst_drain_comb: got st=%0d stall=%b flush=%b rv=%b want 2/00000/11111/0", st, stall, flush, rv);
    else n_pass++;
    drive(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++;
    if ({st, cnt} !== {2'd0, 8'd0})
      $display("FAIL rst_drain_regs: got st=%0d cnt=%0d want 0/0", st, cnt);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int e = 0; e < 4; e++) begin
      drive(5'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int t = 0; t < 1 + DRAIN + 1; t++) drive(5'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    n_total++;
    if ({cnt2, cnt} !== {2'd3, 8'd4})
      $display("FAIL saturation: got cnt2=%0d cnt=%0d want 3/4", cnt2, cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [10:0] e;
    int errs = 0;
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      drive(5'($urandom_range(0, 31) & $urandom_range(0, 31)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
            $urandom_range(0, 1) == 1, ($urandom_range(0, 49) == 0));
      e = exp_comb();
      n_total++;
      if ({stall, flush, rv} !== e || st !== 2'(m_mode) || cause !== m_cause ||
          cnt !== 8'(m_count) || cnt2 !== 2'(m_count2)) begin
        if (errs < 10)
          $display("FAIL random_c%0d: got s=%b f=%b rv=%b st=%0d ca=%b n=%0d n2=%0d want s=%b f=%b rv=%b st=%0d ca=%b n=%0d n2=%0d",
                   t, stall, flush, rv, st, cause, cnt, cnt2, e[10:6], e[5:1], e[0], m_mode, m_cause, m_count, m_count2);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_csr_event();
    test_deferred();
    test_simultaneous();
    test_held_ready();
    test_reset_in_drain();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
